// File: rtl/edge_detector_bank.sv
// edge_detector_bank
//
// Multi-channel edge detector. It sits between external status, button or
// sensor pins and the register or interrupt logic. Each channel runs its own
// chain of stages:
//   raw pin -> synchroniser -> glitch filter -> filtered level -> edge pulses
//   -> mode qualification -> sticky pending flag and saturating counter.
// Channels share no state with one another.
//
// Parameters
//   CHANNELS     number of independent channels (>= 1)
//   SYNC_STAGES  synchroniser depth (>= 2)
//   FILTER_LEN   consecutive mismatching samples needed to accept a change;
//                set it to 0 to bypass the filter
//   CNT_W        width of each event counter (>= 1)
//
// Ports
//   i_clk      clock; all logic runs on the rising edge
//   i_rst      asynchronous reset, active low; clears every register
//   i_in       raw asynchronous inputs, one bit per channel
//   i_mode     per-channel qualifier, bits [2c+1:2c]:
//                00 off, 01 rising, 10 falling, 11 both
//   i_clear    per-channel synchronous clear of the pending flag and counter
//   o_level    filtered level
//   o_posedge  one-cycle pulse when the filtered level rises
//   o_negedge  one-cycle pulse when the filtered level falls
//   o_edge     one-cycle pulse when the filtered level changes
//   o_event    edge qualified by i_mode (combinational, so a mode change
//              takes effect in the same cycle)
//   o_pending  sticky event flag
//   o_count    saturating event counters; channel c is at [c*CNT_W +: CNT_W]
module edge_detector_bank #(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CHANNELS-1:0]       i_in,
    input  logic [2*CHANNELS-1:0]     i_mode,
    input  logic [CHANNELS-1:0]       i_clear,
    output logic [CHANNELS-1:0]       o_level,
    output logic [CHANNELS-1:0]       o_posedge,
    output logic [CHANNELS-1:0]       o_negedge,
    output logic [CHANNELS-1:0]       o_edge,
    output logic [CHANNELS-1:0]       o_event,
    output logic [CHANNELS-1:0]       o_pending,
    output logic [CHANNELS*CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic                   level_q;
        logic                   level_d_q;
        logic                   pend_q;
        logic [CNT_W-1:0]       cnt_q;

        // Synchroniser: shift chain of SYNC_STAGES flops. The oldest stage
        // is the synchronised sample that the filter sees.
        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], i_in[c]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        if (FILTER_LEN == 0) begin : g_nofilt
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    level_q <= 1'b0;
                end else begin
                    level_q <= s;
                end
            end
        end else begin : g_filt
            localparam int            FW   = $clog2(FILTER_LEN + 1);
            localparam logic [FW-1:0] LAST = FW'(FILTER_LEN - 1);
            logic [FW-1:0] fcnt_q;

            // fcnt_q counts the samples so far that disagree with the level.
            // The new level is taken on the FILTER_LEN-th such sample in a
            // row. Any agreeing sample starts the count again from zero.
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    fcnt_q  <= '0;
                    level_q <= 1'b0;
                end else if (s != level_q) begin
                    if (fcnt_q == LAST) begin
                        level_q <= s;
                        fcnt_q  <= '0;
                    end else begin
                        fcnt_q <= fcnt_q + FW'(1);
                    end
                end else begin
                    fcnt_q <= '0;
                end
            end
        end

        // level_d_q, the pending flag and the counter. An event has priority
        // over a clear: if both come in the same cycle, the pending flag
        // stays set and the counter restarts at 1.
        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                level_d_q <= 1'b0;
                pend_q    <= 1'b0;
                cnt_q     <= '0;
            end else begin
                level_d_q <= level_q;

                if (o_event[c]) begin
                    pend_q <= 1'b1;
                end else if (i_clear[c]) begin
                    pend_q <= 1'b0;
                end

                if (i_clear[c]) begin
                    cnt_q <= o_event[c] ? CNT_W'(1) : '0;
                end else if (o_event[c] && (cnt_q != CNT_MAX)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        assign o_level[c]   = level_q;
        assign o_posedge[c] = level_q & ~level_d_q;
        assign o_negedge[c] = ~level_q & level_d_q;
        assign o_edge[c]    = level_q ^ level_d_q;
        assign o_event[c]   = (o_posedge[c] & i_mode[2*c]) |
                              (o_negedge[c] & i_mode[2*c+1]);
        assign o_pending[c] = pend_q;
        assign o_count[c*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_edge_detector_bank.sv
// Testbench for edge_detector_bank: directed scenarios followed by a
// randomized phase. A behavioural reference model predicts every output for
// every cycle, and a separate monitor compares those predictions against the
// DUT.
module tb_edge_detector_bank;
    localparam int CH      = 8;
    localparam int SS      = 2;
    localparam int FL      = 4;
    localparam int CW      = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic [CH-1:0]      i_in;
    logic [2*CH-1:0]    i_mode;
    logic [CH-1:0]      i_clear;
    logic [CH-1:0]      o_level;
    logic [CH-1:0]      o_posedge;
    logic [CH-1:0]      o_negedge;
    logic [CH-1:0]      o_edge;
    logic [CH-1:0]      o_event;
    logic [CH-1:0]      o_pending;
    logic [CH*CW-1:0]   o_count;

    edge_detector_bank #(
        .CHANNELS   (CH),
        .SYNC_STAGES(SS),
        .FILTER_LEN (FL),
        .CNT_W      (CW)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_in      (i_in),
        .i_mode    (i_mode),
        .i_clear   (i_clear),
        .o_level   (o_level),
        .o_posedge (o_posedge),
        .o_negedge (o_negedge),
        .o_edge    (o_edge),
        .o_event   (o_event),
        .o_pending (o_pending),
        .o_count   (o_count)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [CH-1:0]    level;
        logic [CH-1:0]    pos;
        logic [CH-1:0]    neg;
        logic [CH-1:0]    edg;
        logic [CH-1:0]    evt;
        logic [CH-1:0]    pend;
        logic [CH*CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state, kept per channel
    bit m_sync [CH][SS];   // recent raw samples, [SS-1] is the oldest
    bit m_lvl  [CH];       // accepted level
    bit m_lvl_d[CH];       // accepted level one cycle ago
    int m_run  [CH];       // consecutive samples disagreeing with m_lvl
    bit m_pend [CH];
    int m_cnt  [CH];

    logic [CH-1:0]   cur_in;
    logic [2*CH-1:0] cur_mode;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp_v);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < SS; k++) m_sync[c][k] = 1'b0;
            m_lvl[c]   = 1'b0;
            m_lvl_d[c] = 1'b0;
            m_run[c]   = 0;
            m_pend[c]  = 1'b0;
            m_cnt[c]   = 0;
        end
    endfunction

    function automatic bit model_event(int c);
        bit rose;
        bit fell;
        rose = m_lvl[c] && !m_lvl_d[c];
        fell = !m_lvl[c] && m_lvl_d[c];
        return (rose && (i_mode[2*c] == 1'b1)) || (fell && (i_mode[2*c+1] == 1'b1));
    endfunction

    // Advances the model by one rising clock edge, using the inputs present
    // at that edge.
    function automatic void model_step();
        for (int c = 0; c < CH; c++) begin
            bit ev;
            bit s;
            ev = model_event(c);
            s  = m_sync[c][SS-1];
            if (i_clear[c]) m_cnt[c] = ev ? 1 : 0;
            else if (ev && m_cnt[c] < CNT_MAX) m_cnt[c] = m_cnt[c] + 1;
            if (ev) m_pend[c] = 1'b1;
            else if (i_clear[c]) m_pend[c] = 1'b0;
            m_lvl_d[c] = m_lvl[c];
            if (FL == 0) begin
                m_lvl[c] = s;
            end else if (s != m_lvl[c]) begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] == FL) begin
                    m_lvl[c] = s;
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
            for (int k = SS - 1; k > 0; k--) m_sync[c][k] = m_sync[c][k-1];
            m_sync[c][0] = i_in[c];
        end
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        for (int c = 0; c < CH; c++) begin
            e.level[c] = m_lvl[c];
            e.pos[c]   = m_lvl[c] & ~m_lvl_d[c];
            e.neg[c]   = ~m_lvl[c] & m_lvl_d[c];
            e.edg[c]   = m_lvl[c] ^ m_lvl_d[c];
            e.evt[c]   = model_event(c);
            e.pend[c]  = m_pend[c];
            e.cnt[c*CW +: CW] = CW'(m_cnt[c]);
        end
        return e;
    endfunction

    // Runs one clock cycle. The task is entered at a falling edge. It drives
    // the inputs, queues the expected outputs for this cycle, advances the
    // model at the rising edge and returns at the next falling edge.
    task automatic step(input logic [CH-1:0] clr);
        i_in    = cur_in;
        i_mode  = cur_mode;
        i_clear = clr;
        #1;
        sb_q.push_back(model_expect());
        @(posedge i_clk);
        if (i_rst) model_step();
        else model_reset();
        @(negedge i_clk);
    endtask

    // Asserts reset between clock edges. The outputs must clear without any
    // clock edge.
    task automatic async_reset();
        i_rst = 1'b0;
        #1;
        model_reset();
        sb_q.push_back(model_expect());
        check("async_rst_level", o_level, '0);
        check("async_rst_count", o_count, '0);
        check("async_rst_pending", o_pending, '0);
        @(negedge i_clk);
    endtask

    // Monitor: compares each queued expectation with the DUT outputs.
    initial begin
        forever begin
            @(negedge i_clk);
            #2;
            while (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_level",   o_level,   e.level);
                check("sb_posedge", o_posedge, e.pos);
                check("sb_negedge", o_negedge, e.neg);
                check("sb_edge",    o_edge,    e.edg);
                check("sb_event",   o_event,   e.evt);
                check("sb_pending", o_pending, e.pend);
                check("sb_count",   o_count,   e.cnt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        int npos;
        int nneg;
        bit done;
        logic [CH-1:0] clr;

        i_rst    = 1'b0;
        i_in     = '0;
        i_mode   = '0;
        i_clear  = '0;
        cur_in   = '0;
        // ch7 11, ch6 01, ch5 11, ch4 00, ch3 10, ch2 01, ch1 11, ch0 11
        cur_mode = 16'b11_01_11_00_10_01_11_11;
        model_reset();
        @(negedge i_clk);
        repeat (3) step('0);
        check("reset_level", o_level, '0);
        check("reset_count", o_count, '0);

        // Step on ch0: the level must be high after edge SYNC_STAGES+FILTER_LEN = 6
        i_rst     = 1'b1;
        cur_in[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step('0);
            if (n == 5) check("step_level_e5", o_level[0], 1'b0);
            if (n == 6) begin
                check("step_level_e6", o_level[0], 1'b1);
                check("step_posedge_e6", o_posedge[0], 1'b1);
                check("step_edge_e6", o_edge[0], 1'b1);
                check("step_negedge_e6", o_negedge[0], 1'b0);
            end
            if (n == 7) check("step_posedge_e7", o_posedge[0], 1'b0);
        end

        // Glitch rejection on ch1: a 3-cycle pulse must be rejected
        seen = 1'b0;
        cur_in[1] = 1'b1;
        repeat (3) begin step('0); seen = seen | o_level[1] | o_edge[1]; end
        cur_in[1] = 1'b0;
        repeat (8) begin step('0); seen = seen | o_level[1] | o_edge[1]; end
        check("glitch3_rejected", seen, 1'b0);

        // A 4-cycle pulse must pass
        npos = 0;
        nneg = 0;
        cur_in[1] = 1'b1;
        repeat (4) begin step('0); npos += int'(o_posedge[1]); nneg += int'(o_negedge[1]); end
        cur_in[1] = 1'b0;
        repeat (10) begin step('0); npos += int'(o_posedge[1]); nneg += int'(o_negedge[1]); end
        check("glitch4_posedges", npos, 1);
        check("glitch4_negedges", nneg, 1);

        // Mode mask: the same square wave drives ch2..ch5
        repeat (3) begin
            cur_in[5:2] = 4'hF;
            repeat (6) step('0);
            cur_in[5:2] = 4'h0;
            repeat (6) step('0);
        end
        repeat (6) step('0);
        check("mode_cnt_ch2_rise", o_count[2*CW +: CW], 3);
        check("mode_cnt_ch3_fall", o_count[3*CW +: CW], 3);
        check("mode_cnt_ch4_off",  o_count[4*CW +: CW], 0);
        check("mode_cnt_ch5_both", o_count[5*CW +: CW], 6);
        check("mode_pending", o_pending[5:2], 4'b1011);

        // Bring the ch5 counter to 7, then assert clear in the event cycle
        cur_in[5] = 1'b1;
        repeat (6) step('0);
        cur_in[5] = 1'b0;
        repeat (8) step('0);
        check("collide_pre_count", o_count[5*CW +: CW], 7);
        cur_in[5] = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 12 && !done; n++) begin
            clr = '0;
            clr[5] = model_event(5);
            step(clr);
            if (clr[5]) begin
                check("collide_count", o_count[5*CW +: CW], 1);
                check("collide_pending", o_pending[5], 1'b1);
                done = 1'b1;
            end
        end
        check("collide_reached", done, 1'b1);
        step('0);
        clr = '0;
        clr[5] = 1'b1;
        step(clr);
        check("clear_only_count", o_count[5*CW +: CW], 0);
        check("clear_only_pending", o_pending[5], 1'b0);

        // Saturation on ch6 (mode 01): 10 rising events must leave the counter at 7
        repeat (10) begin
            cur_in[6] = 1'b1;
            repeat (5) step('0);
            cur_in[6] = 1'b0;
            repeat (5) step('0);
        end
        repeat (6) step('0);
        check("sat_count", o_count[6*CW +: CW], CNT_MAX);
        check("sat_pending", o_pending[6], 1'b1);

        // Reset while the ch0 filter count is 2 and other channels hold state
        cur_in[0] = 1'b0;
        repeat (4) step('0);
        cur_in = '0;
        async_reset();
        repeat (2) step('0);
        i_rst = 1'b1;
        seen = 1'b0;
        repeat (12) begin step('0); seen = seen | (|o_edge); end
        check("no_pulse_after_rst", seen, 1'b0);

        // Randomized phase
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 5) == 0) cur_in[c] = ~cur_in[c];
            if (cyc % 64 == 0) cur_mode = 16'($urandom);
            clr = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
            if (cyc % 400 == 200) begin
                async_reset();
                repeat ($urandom_range(1, 3)) step('0);
                i_rst = 1'b1;
            end
            step(clr);
        end

        #5;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
